// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// stream framing constants and a state decode helper.
package loader_pkg;

  localparam int LOADER_BYTES_PER_WORD = 4;
  localparam int LOADER_HDR_BYTES      = 2;
  localparam int LOADER_WORD_W         = 8 * LOADER_BYTES_PER_WORD;
  localparam int LOADER_IDX_W          = $clog2(LOADER_BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_CHECK  = 3'd3,
    ST_BYTES  = 3'd4,
    ST_WRITE  = 3'd5,
    ST_START  = 3'd6
  } loader_state_e;

  // States in which the loader offers byte_ready to the host.
  function automatic logic accepts_bytes(input loader_state_e s);
    return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_BYTES);
  endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Big-endian byte-to-word shifter: the first accepted byte ends up in the
// most significant lane, and word_valid_o flags the byte that completes a word.
module byte_word_assembler
  import loader_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     byte_en_i,
  input  logic [7:0]               byte_i,
  output logic [LOADER_WORD_W-1:0] word_o,
  output logic                     word_valid_o
);

  localparam logic [LOADER_IDX_W-1:0] LAST_IDX = LOADER_IDX_W'(LOADER_BYTES_PER_WORD - 1);

  // Only the three leading bytes need storage; the fourth is taken live.
  logic [LOADER_WORD_W-9:0] word_q;
  logic [LOADER_IDX_W-1:0]  idx_q;

  assign word_o       = {word_q, byte_i};
  assign word_valid_o = byte_en_i && !clr_i && (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (clr_i) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (byte_en_i) begin
      word_q <= word_o[LOADER_WORD_W-9:0];
      idx_q  <= idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed big-endian program into instruction memory over
// its external write port, then pulses start to release the CPU.
module imem_loader
  import loader_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              I_MEM_Write_Enable,
  output logic [DATA_W-1:0] I_MEM_Data_In,
  output logic [ADDR_W-1:0] I_MEM_Write_Addr,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int              HDR_W     = 8 * LOADER_HDR_BYTES;
  localparam logic [ADDR_W:0] ADDR_SPAN = {1'b1, {ADDR_W{1'b0}}};

  loader_state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [HDR_W-1:0]  count_q;
  logic [7:0]        hdr_hi_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] waddr_q;
  logic              we_q;
  logic              start_q;
  logic              busy_q;
  logic              ready_q;
  logic              done_q;
  logic              error_q;

  logic                     xfer;
  logic                     asm_clr;
  logic                     asm_en;
  logic                     word_valid;
  logic [LOADER_WORD_W-1:0] asm_word;
  logic [ADDR_W:0]          end_addr;
  logic                     overflow;

  assign xfer     = byte_valid & ready_q;
  assign asm_clr  = abort | (load_req & (state_q == ST_IDLE));
  assign asm_en   = xfer & (state_q == ST_BYTES);
  // One bit wider than the address so BASE_ADDR+N == 2^ADDR_W is still legal.
  assign end_addr = {1'b0, BASE_ADDR} + (ADDR_W + 1)'(count_q);
  assign overflow = end_addr > ADDR_SPAN;

  byte_word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (asm_clr),
    .byte_en_i    (asm_en),
    .byte_i       (byte_data),
    .word_o       (asm_word),
    .word_valid_o (word_valid)
  );

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (load_req) state_d = ST_HDR_HI;
        ST_HDR_HI: if (xfer) state_d = ST_HDR_LO;
        ST_HDR_LO: if (xfer) state_d = ST_CHECK;
        ST_CHECK: begin
          if (overflow)           state_d = ST_IDLE;
          else if (count_q == '0) state_d = ST_START;
          else                    state_d = ST_BYTES;
        end
        ST_BYTES:  if (word_valid) state_d = ST_WRITE;
        ST_WRITE:  state_d = (count_q == HDR_W'(1)) ? ST_START : ST_BYTES;
        ST_START:  state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      count_q  <= '0;
      hdr_hi_q <= '0;
      wdata_q  <= '0;
      waddr_q  <= '0;
      we_q     <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= accepts_bytes(state_d);
      busy_q  <= (state_d != ST_IDLE);
      we_q    <= (state_d == ST_WRITE);
      start_q <= (state_d == ST_START);

      // The write port is loaded only on the way into WRITE and holds otherwise.
      if (state_d == ST_WRITE) begin
        wdata_q <= DATA_W'(asm_word);
        waddr_q <= addr_q;
      end

      if (!abort) begin
        case (state_q)
          ST_IDLE: begin
            if (load_req) begin
              done_q  <= 1'b0;
              error_q <= 1'b0;
              addr_q  <= BASE_ADDR;
            end
          end
          ST_HDR_HI: if (xfer) hdr_hi_q <= byte_data;
          ST_HDR_LO: if (xfer) count_q <= {hdr_hi_q, byte_data};
          ST_CHECK:  if (overflow) error_q <= 1'b1;
          ST_WRITE: begin
            addr_q  <= addr_q + 1'b1;
            count_q <= count_q - 1'b1;
          end
          ST_START:  done_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign byte_ready         = ready_q;
  assign I_MEM_Write_Enable = we_q;
  assign I_MEM_Data_In      = wdata_q;
  assign I_MEM_Write_Addr   = waddr_q;
  assign start              = start_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign error              = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: two instances (base 0 and base 0xFFFE),
// a write scoreboard per instance, a vector table and hand-written corner cases.
module tb_imem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        load_req_a [2];
  logic        abort_a    [2];
  logic        valid_a    [2];
  logic [7:0]  bdata_a    [2];
  logic        ready_a    [2];
  logic        we_a       [2];
  logic [31:0] wdata_a    [2];
  logic [15:0] waddr_a    [2];
  logic        start_a    [2];
  logic        busy_a     [2];
  logic        done_a     [2];
  logic        error_a    [2];

  imem_loader #(.ADDR_W(16), .DATA_W(32), .BASE_ADDR(16'h0000)) dut (
    .clk(clk), .rst(rst), .load_req(load_req_a[0]), .abort(abort_a[0]),
    .byte_valid(valid_a[0]), .byte_data(bdata_a[0]), .byte_ready(ready_a[0]),
    .I_MEM_Write_Enable(we_a[0]), .I_MEM_Data_In(wdata_a[0]), .I_MEM_Write_Addr(waddr_a[0]),
    .start(start_a[0]), .busy(busy_a[0]), .done(done_a[0]), .error(error_a[0])
  );

  imem_loader #(.ADDR_W(16), .DATA_W(32), .BASE_ADDR(16'hFFFE)) dut_hi (
    .clk(clk), .rst(rst), .load_req(load_req_a[1]), .abort(abort_a[1]),
    .byte_valid(valid_a[1]), .byte_data(bdata_a[1]), .byte_ready(ready_a[1]),
    .I_MEM_Write_Enable(we_a[1]), .I_MEM_Data_In(wdata_a[1]), .I_MEM_Write_Addr(waddr_a[1]),
    .start(start_a[1]), .busy(busy_a[1]), .done(done_a[1]), .error(error_a[1])
  );

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [15:0] n;
    logic [31:0] w [4];
    bit          stall;
    int          exp_starts;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  wr_t sb0[$];
  wr_t sb1[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  start_cnt [2];
  int  start_cyc [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_write(input int s);
    wr_t w;
    int  depth;
    depth = (s == 0) ? sb0.size() : sb1.size();
    if (depth == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_write[%0d]: got addr=%h data=%h, expected no write", s, waddr_a[s], wdata_a[s]);
    end else begin
      if (s == 0) w = sb0.pop_front();
      else        w = sb1.pop_front();
      $display("write[%0d] addr=%h data=%h cycle=%0d", s, waddr_a[s], wdata_a[s], cyc);
      check("wr_addr", {16'h0, waddr_a[s]}, {16'h0, w.addr});
      check("wr_data", wdata_a[s], w.data);
      check("wr_cycle", cyc, w.cyc);
    end
  endtask

  // Scoreboard consumer: outputs are sampled half a cycle after the edge.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (we_a[s] === 1'b1) check_write(s);
      if (start_a[s] === 1'b1) begin
        start_cnt[s]++;
        start_cyc[s] = cyc;
        $display("start[%0d] cycle=%0d", s, cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send_byte(input int s, input logic [7:0] b, input bit stall, input bit last,
                           input logic [15:0] waddr, input logic [31:0] wword, output int hs);
    int n;
    hs = -1;
    if (stall) begin
      n = int'($urandom_range(0, 3));
      repeat (n) begin
        valid_a[s] = 1'b0;
        @(negedge clk);
      end
    end
    valid_a[s] = 1'b1;
    bdata_a[s] = b;
    n = 0;
    while (ready_a[s] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ready_a[s] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout[%0d]: got byte_ready=%b, expected 1 within 100 cycles", s, ready_a[s]);
    end else begin
      hs = cyc + 1;
      if (last) begin
        if (s == 0) sb0.push_back('{waddr, wword, hs});
        else        sb1.push_back('{waddr, wword, hs});
      end
    end
    @(negedge clk);
  endtask

  task automatic do_load(input int s, input logic [15:0] n, input int nsend, input logic [31:0] w [4],
                         input bit stall, input logic [15:0] base, output int hs_lo, output int last_e);
    int hs;
    load_req_a[s] = 1'b1;
    @(negedge clk);
    load_req_a[s] = 1'b0;
    send_byte(s, n[15:8], stall, 1'b0, 16'h0, 32'h0, hs);
    send_byte(s, n[7:0], stall, 1'b0, 16'h0, 32'h0, hs_lo);
    last_e = -1;
    for (int i = 0; i < nsend; i++) begin
      for (int b = 0; b < 4; b++) begin
        send_byte(s, w[i][31-8*b -: 8], stall, b == 3, base + 16'(i), w[i], hs);
        if (b == 3) last_e = hs;
      end
    end
    valid_a[s] = 1'b0;
  endtask

  task automatic wait_end(input int s);
    int n = 0;
    while (done_a[s] !== 1'b1 && error_a[s] !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL end_timeout[%0d]: got done=%b error=%b, expected one set within 60 cycles", s, done_a[s], error_a[s]);
    end
    @(negedge clk);
  endtask

  vec_t        vecs [5];
  logic [31:0] wbuf [4];
  int          hs_lo, last_e, st0, hs;

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected $finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      load_req_a[s] = 1'b0;
      abort_a[s]    = 1'b0;
      valid_a[s]    = 1'b0;
      bdata_a[s]    = 8'h00;
      start_cnt[s]  = 0;
      start_cyc[s]  = -1;
    end

    vecs[0] = '{16'd2, '{32'h20010005, 32'h20420001, 32'h0, 32'h0}, 1'b0, 1, 1'b1, 1'b0};
    vecs[1] = '{16'd0, '{32'h0, 32'h0, 32'h0, 32'h0}, 1'b0, 1, 1'b1, 1'b0};
    vecs[2] = '{16'd3, '{32'hA5A5_0F0F, 32'h0000_0013, 32'hFFFF_FFFF, 32'h0}, 1'b0, 1, 1'b1, 1'b0};
    vecs[3] = '{16'd3, '{32'hA5A5_0F0F, 32'h0000_0013, 32'hFFFF_FFFF, 32'h0}, 1'b1, 1, 1'b1, 1'b0};
    vecs[4] = '{16'd4, '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0102_0304, 32'h8000_0001}, 1'b1, 1, 1'b1, 1'b0};

    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_we", {31'h0, we_a[0]}, 32'h0);
    check("rst_start", {31'h0, start_a[0]}, 32'h0);
    check("rst_busy", {31'h0, busy_a[0]}, 32'h0);
    check("rst_done", {31'h0, done_a[0]}, 32'h0);
    check("rst_error", {31'h0, error_a[0]}, 32'h0);
    check("rst_ready", {31'h0, ready_a[0]}, 32'h0);
    check("rst_data", wdata_a[0], 32'h0);
    check("rst_addr", {16'h0, waddr_a[0]}, 32'h0);
    check("rst_ready_hi", {31'h0, ready_a[1]}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Table-driven loads on the base-0 instance.
    foreach (vecs[v]) begin
      st0 = start_cnt[0];
      wbuf = vecs[v].w;
      do_load(0, vecs[v].n, int'(vecs[v].n), wbuf, vecs[v].stall, 16'h0000, hs_lo, last_e);
      wait_end(0);
      check($sformatf("v%0d_starts", v), start_cnt[0] - st0, vecs[v].exp_starts);
      check($sformatf("v%0d_done", v), {31'h0, done_a[0]}, {31'h0, vecs[v].exp_done});
      check($sformatf("v%0d_error", v), {31'h0, error_a[0]}, {31'h0, vecs[v].exp_err});
      check($sformatf("v%0d_busy", v), {31'h0, busy_a[0]}, 32'h0);
      check($sformatf("v%0d_ready", v), {31'h0, ready_a[0]}, 32'h0);
      check($sformatf("v%0d_pending", v), sb0.size(), 0);
      if (vecs[v].n == 16'd0) check($sformatf("v%0d_start_cyc", v), start_cyc[0], hs_lo + 1);
      else                    check($sformatf("v%0d_start_cyc", v), start_cyc[0], last_e + 1);
      $display("vector %0d: n=%0d stall=%0d done=%b error=%b", v, vecs[v].n, vecs[v].stall, done_a[0], error_a[0]);
    end

    // Overflow: base 0xFFFE with three words must not write or start.
    wbuf = '{32'h0, 32'h0, 32'h0, 32'h0};
    do_load(1, 16'd3, 0, wbuf, 1'b0, 16'hFFFE, hs_lo, last_e);
    wait_end(1);
    repeat (3) @(negedge clk);
    check("ovf_error", {31'h0, error_a[1]}, 32'h1);
    check("ovf_done", {31'h0, done_a[1]}, 32'h0);
    check("ovf_busy", {31'h0, busy_a[1]}, 32'h0);
    check("ovf_ready", {31'h0, ready_a[1]}, 32'h0);
    check("ovf_starts", start_cnt[1], 0);
    $display("overflow: error=%b done=%b", error_a[1], done_a[1]);

    // Exact fit at the top of the address space.
    wbuf = '{32'hCAFE_0001, 32'hCAFE_0002, 32'h0, 32'h0};
    do_load(1, 16'd2, 2, wbuf, 1'b0, 16'hFFFE, hs_lo, last_e);
    wait_end(1);
    check("fit_done", {31'h0, done_a[1]}, 32'h1);
    check("fit_error", {31'h0, error_a[1]}, 32'h0);
    check("fit_starts", start_cnt[1], 1);
    check("fit_pending", sb1.size(), 0);

    // Abort after six data bytes: first word stays written, no start.
    st0 = start_cnt[0];
    wbuf = '{32'h1111_2222, 32'h3333_4444, 32'h0, 32'h0};
    load_req_a[0] = 1'b1;
    @(negedge clk);
    load_req_a[0] = 1'b0;
    send_byte(0, 8'h00, 1'b0, 1'b0, 16'h0, 32'h0, hs);
    send_byte(0, 8'h02, 1'b0, 1'b0, 16'h0, 32'h0, hs);
    for (int b = 0; b < 6; b++)
      send_byte(0, wbuf[b/4][31-8*(b%4) -: 8], 1'b0, b == 3, 16'h0000, wbuf[0], hs);
    valid_a[0] = 1'b0;
    abort_a[0] = 1'b1;
    @(negedge clk);
    abort_a[0] = 1'b0;
    check("abort_busy", {31'h0, busy_a[0]}, 32'h0);
    check("abort_ready", {31'h0, ready_a[0]}, 32'h0);
    repeat (5) @(negedge clk);
    check("abort_starts", start_cnt[0] - st0, 0);
    check("abort_done", {31'h0, done_a[0]}, 32'h0);
    check("abort_pending", sb0.size(), 0);
    $display("abort: busy=%b done=%b", busy_a[0], done_a[0]);

    // Abort in the same cycle as load_req wins.
    abort_a[0] = 1'b1;
    load_req_a[0] = 1'b1;
    @(negedge clk);
    abort_a[0] = 1'b0;
    load_req_a[0] = 1'b0;
    check("abort_req_busy", {31'h0, busy_a[0]}, 32'h0);

    wbuf = '{32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0};
    do_load(0, 16'd1, 1, wbuf, 1'b0, 16'h0000, hs_lo, last_e);
    wait_end(0);
    check("reload_done", {31'h0, done_a[0]}, 32'h1);
    check("reload_pending", sb0.size(), 0);

    // Busy load_req ignored, then async reset in the middle of a WRITE cycle.
    wbuf = '{32'h0BAD_F00D, 32'h7777_8888, 32'h0, 32'h0};
    load_req_a[0] = 1'b1;
    @(negedge clk);
    load_req_a[0] = 1'b0;
    send_byte(0, 8'h00, 1'b0, 1'b0, 16'h0, 32'h0, hs);
    send_byte(0, 8'h02, 1'b0, 1'b0, 16'h0, 32'h0, hs);
    send_byte(0, 8'h0B, 1'b0, 1'b0, 16'h0, 32'h0, hs);
    load_req_a[0] = 1'b1;
    send_byte(0, 8'hAD, 1'b0, 1'b0, 16'h0, 32'h0, hs);
    load_req_a[0] = 1'b0;
    send_byte(0, 8'hF0, 1'b0, 1'b0, 16'h0, 32'h0, hs);
    send_byte(0, 8'h0D, 1'b0, 1'b1, 16'h0000, wbuf[0], hs);
    valid_a[0] = 1'b0;
    check("mid_write_we", {31'h0, we_a[0]}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("arst_we", {31'h0, we_a[0]}, 32'h0);
    check("arst_busy", {31'h0, busy_a[0]}, 32'h0);
    check("arst_ready", {31'h0, ready_a[0]}, 32'h0);
    check("arst_done", {31'h0, done_a[0]}, 32'h0);
    check("arst_data", wdata_a[0], 32'h0);
    check("arst_done_hi", {31'h0, done_a[1]}, 32'h0);
    check("arst_error_hi", {31'h0, error_a[1]}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_pending", sb0.size(), 0);

    wbuf = '{32'h5555_AAAA, 32'h0, 32'h0, 32'h0};
    do_load(0, 16'd1, 1, wbuf, 1'b1, 16'h0000, hs_lo, last_e);
    wait_end(0);
    check("post_rst_done", {31'h0, done_a[0]}, 32'h1);
    check("post_rst_pending", sb0.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
